dbi_decoder: RTL and testbench

Receive-side Data Bus Inversion (DBI) decoder for the ALU operand/result bus. The sender inverts a word when that lowers bus zeros (DC mode) or bus toggles (AC mode), and flags it with a `dbi` bit. This block undoes that inversion with a per-bit NOT, checks that each received word obeys the encoding rule, and counts inverted and illegal words. It sits between the bus pins and the ALU operand registers. It has a one-entry registered output stage with a valid/ready handshake.

---
 rtl/dbi_if.sv | 21 ++
 rtl/dbi_decoder.sv | 47 ++++
 tb/tb_dbi_decoder.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/dbi_if.sv
// dbi_if: bus-side word handshake into the DBI decoder and decoded-word handshake out of it.
interface dbi_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_dbi;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_err;
    modport master (
        output in_valid, in_data, in_dbi, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );
    modport slave (
        input  in_valid, in_data, in_dbi, out_ready,
        output in_ready, out_valid, out_data, out_err
    );
endinterface

// File: rtl/dbi_decoder.sv
// dbi_decoder: undoes bus inversion, checks the DC/AC encoding rule and counts inverted and illegal words.
module dbi_decoder #(
    parameter int WIDTH = 8,
    parameter int MODE  = 0,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    dbi_if.slave             bus,
    output logic [CNT_W-1:0] inv_count,
    output logic [CNT_W-1:0] err_count
);
    localparam int CW = $clog2(WIDTH + 1);
    logic [WIDTH-1:0] prev_bus;
    logic [WIDTH-1:0] chk;
    logic [CW-1:0]    cnt;
    logic             acc;
    logic             bad;
    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign acc = bus.in_valid && bus.in_ready;
    // DC mode counts zeros on the bus, AC mode counts toggles against the previous bus word
    assign chk = (MODE != 0) ? (bus.in_data ^ prev_bus) : ~bus.in_data;
    always_comb begin
        cnt = '0;
        for (int i = 0; i < WIDTH; i++) cnt = cnt + CW'(chk[i]);
    end
    assign bad = cnt > CW'(WIDTH / 2);
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_err   <= 1'b0;
            inv_count     <= '0;
            err_count     <= '0;
            prev_bus      <= '1;
        end else begin
            bus.out_valid <= acc || (bus.out_valid && !bus.out_ready);
            if (acc) begin
                bus.out_data <= bus.in_dbi ? ~bus.in_data : bus.in_data;
                bus.out_err  <= bad;
                prev_bus     <= bus.in_data;
                if (bus.in_dbi && inv_count != '1) inv_count <= inv_count + 1'b1;
                if (bad && err_count != '1) err_count <= err_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_dbi_decoder.sv
// tb_dbi_decoder: table vectors, hand-written corner sequences and a randomized model check
// across DC (16-bit counters), AC and DC (2-bit counters) instances driven in lockstep.
module tb_dbi_decoder;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int n = 0;
    int fails = 0;
    logic [15:0] inv0, err0, inv1, err1;
    logic [1:0]  inv2, err2;

    dbi_if #(.WIDTH(8)) b0 ();
    dbi_if #(.WIDTH(8)) b1 ();
    dbi_if #(.WIDTH(8)) b2 ();

    dbi_decoder #(.WIDTH(8), .MODE(0), .CNT_W(16)) u0 (
        .clk(clk), .rst(rst), .bus(b0), .inv_count(inv0), .err_count(err0));
    dbi_decoder #(.WIDTH(8), .MODE(1), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst), .bus(b1), .inv_count(inv1), .err_count(err1));
    dbi_decoder #(.WIDTH(8), .MODE(0), .CNT_W(2)) u2 (
        .clk(clk), .rst(rst), .bus(b2), .inv_count(inv2), .err_count(err2));

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       dbi;
        logic [7:0] exp_d;
        logic       exp_e0;
        logic       exp_e1;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic dbi, input logic ord);
        b0.in_valid = v; b0.in_data = d; b0.in_dbi = dbi; b0.out_ready = ord;
        b1.in_valid = v; b1.in_data = d; b1.in_dbi = dbi; b1.out_ready = ord;
        b2.in_valid = v; b2.in_data = d; b2.in_dbi = dbi; b2.out_ready = ord;
    endtask

    task automatic do_reset();
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        logic        exp_v, e0, e1, acc, rdy, iv, dbi, ord;
        logic [7:0]  exp_d, prev, d;
        int          ic, e0c, e1c, ic2, e2c;

        tbl[0] = '{8'h00, 1'b0, 8'h00, 1'b1, 1'b1};
        tbl[1] = '{8'hF0, 1'b0, 8'hF0, 1'b0, 1'b0};
        tbl[2] = '{8'h0F, 1'b1, 8'hF0, 1'b0, 1'b1};
        tbl[3] = '{8'h07, 1'b0, 8'h07, 1'b1, 1'b0};
        tbl[4] = '{8'hFF, 1'b1, 8'h00, 1'b0, 1'b1};
        tbl[5] = '{8'h1F, 1'b0, 8'h1F, 1'b0, 1'b0};

        drive(1'b1, 8'h5A, 1'b1, 1'b1);
        do_reset();
        chk("rst out_valid", b0.out_valid, 0);
        chk("rst out_data", b0.out_data, 0);
        chk("rst out_err", b0.out_err, 0);
        chk("rst inv_count", inv0, 0);
        chk("rst err_count", err0, 0);
        chk("rst in_ready", b0.in_ready, 1);

        for (int i = 0; i < 6; i++) begin
            drive(1'b1, tbl[i].d, tbl[i].dbi, 1'b1);
            cyc();
            chk("tbl out_valid", b0.out_valid, 1);
            chk("tbl dc out_data", b0.out_data, tbl[i].exp_d);
            chk("tbl dc out_err", b0.out_err, tbl[i].exp_e0);
            chk("tbl ac out_data", b1.out_data, tbl[i].exp_d);
            chk("tbl ac out_err", b1.out_err, tbl[i].exp_e1);
        end
        chk("tbl dc inv_count", inv0, 2);
        chk("tbl dc err_count", err0, 2);
        chk("tbl ac err_count", err1, 3);
        chk("tbl sat2 err_count", err2, 2);

        drive(1'b1, 8'hA5, 1'b0, 1'b1);
        cyc();
        chk("bp first word", b0.out_data, 8'hA5);
        drive(1'b1, 8'h3C, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp in_ready low", b0.in_ready, 0);
            cyc();
            chk("bp hold data", b0.out_data, 8'hA5);
            chk("bp hold valid", b0.out_valid, 1);
        end
        drive(1'b1, 8'h3C, 1'b0, 1'b1);
        #1;
        chk("bp in_ready on drain", b0.in_ready, 1);
        cyc();
        chk("bp new word", b0.out_data, 8'h3C);
        chk("bp no bubble", b0.out_valid, 1);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        cyc();
        chk("bp drained valid", b0.out_valid, 0);
        chk("bp drained data kept", b0.out_data, 8'h3C);

        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'hF0, 1'b1, 1'b1);
            cyc();
            chk("sat2 inv_count", inv2, (i < 3) ? i + 1 : 3);
            chk("sat16 inv_count", inv0, i + 1);
        end

        drive(1'b1, 8'h00, 1'b0, 1'b1);
        cyc();
        drive(1'b1, 8'h11, 1'b1, 1'b0);
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("mid rst out_valid", b0.out_valid, 0);
        chk("mid rst inv_count", inv0, 0);
        chk("mid rst err_count", err0, 0);
        chk("mid rst ac err_count", err1, 0);
        chk("mid rst in_ready", b0.in_ready, 1);
        drive(1'b1, 8'hFF, 1'b0, 1'b1);
        cyc();
        chk("mid rst ac prev idle", b1.out_err, 0);
        chk("mid rst ac data", b1.out_data, 8'hFF);

        do_reset();
        exp_v = 0; exp_d = 0; e0 = 0; e1 = 0; prev = 8'hFF;
        ic = 0; e0c = 0; e1c = 0; ic2 = 0; e2c = 0;
        for (int k = 0; k < 400; k++) begin
            iv = ($urandom % 4) != 0;
            d = 8'($urandom);
            dbi = 1'($urandom);
            ord = ($urandom % 4) != 0;
            drive(iv, d, dbi, ord);
            #1;
            rdy = !exp_v || ord;
            chk("rnd dc in_ready", b0.in_ready, rdy);
            chk("rnd ac in_ready", b1.in_ready, rdy);
            acc = iv && rdy;
            if (acc) begin
                exp_d = dbi ? ~d : d;
                e0 = (8 - $countones(d)) > 4;
                e1 = $countones(d ^ prev) > 4;
                prev = d;
                if (dbi) begin
                    ic++;
                    ic2 = (ic2 < 3) ? ic2 + 1 : 3;
                end
                if (e0) begin
                    e0c++;
                    e2c = (e2c < 3) ? e2c + 1 : 3;
                end
                if (e1) e1c++;
            end
            exp_v = acc || (exp_v && !ord);
            cyc();
            chk("rnd out_valid", b0.out_valid, exp_v);
            chk("rnd ac out_valid", b1.out_valid, exp_v);
            chk("rnd dc out_data", b0.out_data, exp_d);
            chk("rnd dc out_err", b0.out_err, e0);
            chk("rnd ac out_data", b1.out_data, exp_d);
            chk("rnd ac out_err", b1.out_err, e1);
            chk("rnd dc inv_count", inv0, ic);
            chk("rnd dc err_count", err0, e0c);
            chk("rnd ac err_count", err1, e1c);
            chk("rnd sat2 inv_count", inv2, ic2);
            chk("rnd sat2 err_count", err2, e2c);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n, fails);
        $finish;
    end
endmodule
